// File: rtl/sipo_word_pkg.sv
// Shared types for the serial-to-parallel word assembler and its output FIFO.
package sipo_word_pkg;

    localparam int unsigned DefaultWordWidth = 16;

    typedef logic [DefaultWordWidth-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } asm_state_e;

    typedef struct packed {
        word_t word;
        logic  parity_err;
    } fifo_entry_t;

endpackage

// File: rtl/sipo_word_fifo.sv
// First-word fall-through FIFO; a push into a full FIFO is accepted only when a pop frees a slot
// in the same cycle. Head reads as zero when empty.
module sipo_word_fifo
    import sipo_word_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter type         entry_t    = fifo_entry_t
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   push_i,
    input  logic   pop_i,
    input  entry_t entry_i,
    output entry_t head_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PtrW:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW:0] rd_ptr_q, rd_ptr_d;
    entry_t        mem_q [FIFO_DEPTH];
    entry_t        mem_d [FIFO_DEPTH];
    logic          do_push, do_pop;

    always_comb begin
        empty_o = (wr_ptr_q == rd_ptr_q);
        full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                  (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);

        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[PtrW-1:0]] = entry_i;
        end
        wr_ptr_d = wr_ptr_q + (PtrW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (PtrW+1)'(do_pop);

        head_o = empty_o ? '0 : mem_q[rd_ptr_q[PtrW-1:0]];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/sipo_word_assembler.sv
// Assembles qualified serial bits into words and queues them on a valid/ready interface.
// Define SIPO_WORD_ASSEMBLER_PARITY_CHECK_EN to expect a trailing even-parity bit per frame.
module sipo_word_assembler
    import sipo_word_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = DefaultWordWidth,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned MSB_FIRST  = 1
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic                  Serial_Data_In,
    input  logic                  Serial_Valid_In,
    input  logic                  Frame_Sync_In,
    output logic [WORD_WIDTH-1:0] Word_Out,
    output logic                  Word_Valid_Out,
    input  logic                  Word_Ready_In,
    output logic                  Overflow_Out,
`ifdef SIPO_WORD_ASSEMBLER_PARITY_CHECK_EN
    output logic                  Parity_Error_Out,
    output logic [$clog2(WORD_WIDTH+2)-1:0] Bit_Count_Out
`else
    output logic [$clog2(WORD_WIDTH+1)-1:0] Bit_Count_Out
`endif
);

`ifdef SIPO_WORD_ASSEMBLER_PARITY_CHECK_EN
    localparam int unsigned CntW      = $clog2(WORD_WIDTH + 2);
    localparam asm_state_e  AfterData = PARITY;
`else
    localparam int unsigned CntW      = $clog2(WORD_WIDTH + 1);
    localparam asm_state_e  AfterData = IDLE;
`endif
    localparam logic [CntW-1:0] LastData = CntW'(WORD_WIDTH - 1);

    typedef struct packed {
        logic [WORD_WIDTH-1:0] word;
        logic                  parity_err;
    } entry_t;

    asm_state_e            state_q, state_d;
    logic [WORD_WIDTH-1:0] sr_q, sr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  push;
    entry_t                push_entry;
    entry_t                head;
    logic                  full, empty;

    function automatic logic [WORD_WIDTH-1:0] shift_in(input logic [WORD_WIDTH-1:0] base,
                                                       input logic                  b);
        if (MSB_FIRST != 0) begin
            return {base[WORD_WIDTH-2:0], b};
        end
        return {b, base[WORD_WIDTH-1:1]};
    endfunction

    always_ff @(posedge Clk_In) begin
        if (!Reset_In) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame sync always wins; the bit arriving with it starts a fresh word.
    always_comb begin
        state_d = state_q;
        if (Frame_Sync_In) begin
            state_d = Serial_Valid_In ? SHIFT : IDLE;
        end else if (Serial_Valid_In) begin
            unique case (state_q)
                IDLE:    state_d = SHIFT;
                SHIFT:   state_d = (cnt_q == LastData) ? AfterData : SHIFT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        push       = 1'b0;
        push_entry = '0;
        if (Frame_Sync_In) begin
            cnt_d = Serial_Valid_In ? CntW'(1) : '0;
            if (Serial_Valid_In) begin
                sr_d = shift_in('0, Serial_Data_In);
            end
        end else if (Serial_Valid_In) begin
`ifdef SIPO_WORD_ASSEMBLER_PARITY_CHECK_EN
            if (state_q == PARITY) begin
                push                  = 1'b1;
                push_entry.word       = sr_q;
                push_entry.parity_err = ^{sr_q, Serial_Data_In};
                cnt_d                 = '0;
            end else begin
                sr_d  = shift_in(sr_q, Serial_Data_In);
                cnt_d = cnt_q + CntW'(1);
            end
`else
            sr_d = shift_in(sr_q, Serial_Data_In);
            if (state_q == SHIFT && cnt_q == LastData) begin
                push            = 1'b1;
                push_entry.word = sr_d;
                cnt_d           = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
`endif
        end
        // A completed word is lost only if the FIFO stays full through this edge.
        ovf_d = ovf_q | (push && full && !(Word_Ready_In && !empty));
    end

    always_ff @(posedge Clk_In) begin
        if (!Reset_In) begin
            sr_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    sipo_word_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .entry_t    (entry_t)
    ) u_fifo (
        .clk_i   (Clk_In),
        .rst_ni  (Reset_In),
        .push_i  (push),
        .pop_i   (Word_Ready_In),
        .entry_i (push_entry),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign Word_Out       = head.word;
    assign Word_Valid_Out = !empty;
    assign Overflow_Out   = ovf_q;
    assign Bit_Count_Out  = cnt_q;
`ifdef SIPO_WORD_ASSEMBLER_PARITY_CHECK_EN
    assign Parity_Error_Out = head.parity_err;
`endif

endmodule

// File: doc/sipo_word_assembler.md
Name: sipo_word_assembler

Overview:
- Downstream consumer of the serial bit stream that feeds the 16-bit SIPO shift register.
- Shifts qualified serial bits into a word, counts them, and pushes each completed word into a small output FIFO.
- Presents words on a valid/ready interface, so parallel logic never has to sample a free-running shift register at the right instant.
- Also provides frame alignment and overflow reporting.

Parameters:
- WORD_WIDTH, 16, bits per assembled word (>=2).
- FIFO_DEPTH, 2, output FIFO entries (power of 2, >=2).
- MSB_FIRST, 1, 1 = first received bit lands in Word_Out[WORD_WIDTH-1]; 0 = first bit lands in Word_Out[0].

Ports:
- Clk_In  input  1  single clock, all logic on rising edge.
- Reset_In  input  1  synchronous, active-low reset.
- Serial_Data_In  input  1  serial bit, sampled only when Serial_Valid_In=1.
- Serial_Valid_In  input  1  qualifies Serial_Data_In for this cycle.
- Frame_Sync_In  input  1  discards any partial word; the bit in the same cycle, if valid, becomes bit 0 of a new word.
- Word_Out  output  WORD_WIDTH  FIFO head word; 0 when empty.
- Word_Valid_Out  output  1  FIFO not empty.
- Word_Ready_In  input  1  consumer accepts the head word when Word_Valid_Out&&Word_Ready_In.
- Overflow_Out  output  1  sticky; set when a completed word is dropped.
- Bit_Count_Out  output  $clog2(WORD_WIDTH+1)  bits held in the current partial word.

Behaviour:
- Reset: when Reset_In=0 at a clock edge, clear the shift register, bit counter, FIFO pointers and occupancy, and Overflow_Out. Word_Valid_Out=0, Word_Out=0, Bit_Count_Out=0. Any partial word is lost.
- FSM states:
  - IDLE: count=0.
  - SHIFT: 0<count<WORD_WIDTH.
  - IDLE->SHIFT on a valid bit.
  - SHIFT->IDLE on the completing bit or on Frame_Sync_In without a valid bit.
- Shift, MSB_FIRST=1: sr <= {sr[W-2:0], bit}.
- Shift, MSB_FIRST=0: sr <= {bit, sr[W-1:1]}.
- Completion: a valid bit arriving with count==WORD_WIDTH-1 forms the word combinationally (sr plus the new bit) and pushes it on that edge. Word_Valid_Out rises the next cycle, so latency is 1 cycle from the last bit's edge. The counter returns to 0.
- Serial_Valid_In=0: shift register and counter hold. Gaps of any length are legal.
- Frame_Sync_In=1:
  - With Serial_Valid_In=1: count <= 1 and the bit enters the shift register.
  - With Serial_Valid_In=0: count <= 0.
  - A partial word at sync is discarded and never pushed.
  - Sync overrides completion: a word at count==W-1 is discarded.
- FIFO:
  - First-word fall-through. A pop occurs when Word_Valid_Out&&Word_Ready_In.
  - Push and pop in the same cycle: both occur; occupancy is unchanged. This includes the full case (pop frees the slot).
  - Push when full with no pop: the word is dropped, FIFO contents are unchanged, and Overflow_Out <= 1 until reset.
  - Pop when empty cannot occur, because Word_Valid_Out=0.
- Word_Ready_In is ignored when the FIFO is empty. No combinational path from Word_Ready_In to Word_Valid_Out.
- Pointers wrap modulo FIFO_DEPTH. Occupancy is tracked with an extra pointer bit.

Optional Feature:
- Macro: SIPO_WORD_ASSEMBLER_PARITY_CHECK_EN.
- Defined:
  - Each frame is WORD_WIDTH+1 bits; the final bit is the even-parity bit over the word.
  - Add state PARITY, entered after WORD_WIDTH data bits. Push happens on the parity bit.
  - Each FIFO entry stores a parity_err flag.
  - Added output port Parity_Error_Out (1 bit) is valid alongside Word_Valid_Out; it is 0 at reset and when empty.
  - The word is still delivered on error.
  - Bit_Count_Out width becomes $clog2(WORD_WIDTH+2).
- Undefined: port absent, no PARITY state, frames are WORD_WIDTH bits.

Decomposition:
- Package sipo_word_pkg:
  - Default WORD_WIDTH constant.
  - word_t typedef.
  - asm_state_e enum {IDLE, SHIFT, PARITY}.
  - fifo_entry_t struct {word_t word; logic parity_err;}.
- One sub-module: sipo_word_fifo.
  - Parameterised FIFO_DEPTH.
  - Ports: push/pop/entry in/head out, full/empty.
  - Must implement the push-when-full-with-pop rule.

Test Plan:
- Send 0xA5C3 MSB-first, 16 consecutive valid bits, Ready=1 -> Word_Out=0xA5C3 with Valid=1 one cycle after the 16th bit edge, then Valid=0 after the pop.
- Send 0xA5C3 with an idle gap of 3 cycles after bit 7; also MSB_FIRST=0 with 0x00FF sent LSB-first -> words 0xA5C3 and 0x00FF; Bit_Count_Out holds at 8 during the gap.
- Ready=0, send 0x0001, 0x0002, 0x0003 -> 0x0001 and 0x0002 retained; 0x0003 dropped; Overflow_Out=1 and sticky. Raise Ready -> 0x0001 then 0x0002 popped; Overflow_Out stays 1.
- FIFO full, Ready=1 pulsed exactly on the completion edge of 0x0004 -> no overflow; order is 0x0002, 0x0004.
- 5 random bits, then Frame_Sync_In with the first bit of 0x1234, then the remaining 15 bits -> only 0x1234 delivered. A separate run drops Reset_In=0 at count=9 -> all outputs 0; the next full 16 bits give the correct word.
- With macro: frame 0x8001+parity 0 -> Parity_Error_Out=0; frame 0x8001+parity 1 -> Parity_Error_Out=1, Word_Out=0x8001.
